exc_ctrl_unit: RTL and testbench

- Sequential exception/interrupt controller for the single-cycle LEGv8 core; successor to the purely combinational exception-decode flags (NotAnInstr, ERet).
- Takes decode-stage flags and N level-sensitive external IRQ lines, arbitrates them, and latches ELR (return PC) and ESR (cause).
- Drives the fetch redirect, flush and ERET return, and tracks handler mode through a small FSM.
- Sits between maindec/decode and the PC-select mux.

---
 rtl/exc_ctrl_unit.sv | 164 ++++++++++++++++
 tb/tb_exc_ctrl_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_unit.sv
// exc_ctrl_unit: exception / interrupt controller for the single-cycle LEGv8 core.
// Arbitrates decoder faults and level-sensitive IRQ lines, latches the return PC
// (ELR) and cause code (ESR), and drives fetch redirect, flush and ERET return.
// Handler tracking uses a three-state FSM: NORMAL -> HANDLER -> RETURN -> NORMAL.
// Optional build macro: EXC_IRQ_MASK_EN adds a writable per-line IRQ mask register.
module exc_ctrl_unit #(
  parameter int          N_IRQ      = 4,
  parameter int          PC_W       = 64,
  parameter int          ESR_W      = 4,
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic [PC_W-1:0]  pc_dec,
  input  logic [N_IRQ-1:0] irq_req,
`ifdef EXC_IRQ_MASK_EN
  input  logic             irq_mask_we,
  input  logic [N_IRQ-1:0] irq_mask_wdata,
`endif
  output logic [N_IRQ-1:0] irq_ack,
  output logic             exc_take,
  output logic [PC_W-1:0]  exc_vector,
  output logic             eret_take,
  output logic             flush,
  output logic [PC_W-1:0]  elr_out,
  output logic [ESR_W-1:0] esr_out,
  output logic             in_handler,
  output logic             dbl_fault
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    HANDLER = 2'd1,
    RETURN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   irq_ack_q, irq_ack_d;
  logic               exc_take_q, exc_take_d;
  logic               eret_take_q, eret_take_d;
  logic [PC_W-1:0]    elr_q, elr_d;
  logic [ESR_W-1:0]   esr_q, esr_d;
  logic               in_handler_q, in_handler_d;
  logic               dbl_fault_q, dbl_fault_d;

  logic [N_IRQ-1:0]   eff_req;
  logic [N_IRQ-1:0]   irq_sel;
  logic [ESR_W-1:0]   irq_code;
  logic               fault;

`ifdef EXC_IRQ_MASK_EN
  logic [N_IRQ-1:0]   mask_q, mask_d;

  // Mask register: a write lands on the edge, so arbitration in the same cycle sees the old mask
  always_comb begin
    mask_d = mask_q;
    if (irq_mask_we) mask_d = irq_mask_wdata;
  end

  // Mask state register, all lines enabled out of reset
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '1;
    else       mask_q <= mask_d;
  end

  assign eff_req = irq_req & mask_q;
`else
  assign eff_req = irq_req;
`endif

  // Fixed-priority pick of the lowest-numbered pending request and its cause code
  always_comb begin
    irq_sel  = '0;
    irq_code = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eff_req[i]) begin
        irq_sel    = '0;
        irq_sel[i] = 1'b1;
        irq_code   = ESR_W'(i + 2);
      end
    end
  end

  // An ERET outside the handler is illegal and is reported as an invalid opcode
  assign fault = not_an_instr | eret;

  // Next-state and registered-output logic; pulses default low so they last one cycle
  always_comb begin
    state_d     = state_q;
    irq_ack_d   = '0;
    exc_take_d  = 1'b0;
    eret_take_d = 1'b0;
    elr_d       = elr_q;
    esr_d       = esr_q;
    dbl_fault_d = dbl_fault_q;
    if (instr_valid) begin
      unique case (state_q)
        NORMAL, RETURN: begin
          if (fault) begin
            elr_d      = pc_dec;
            esr_d      = ESR_W'(1);
            exc_take_d = 1'b1;
            state_d    = HANDLER;
          end else if (state_q == NORMAL && (|eff_req)) begin
            elr_d      = pc_dec;
            esr_d      = irq_code;
            irq_ack_d  = irq_sel;
            exc_take_d = 1'b1;
            state_d    = HANDLER;
          end else if (state_q == RETURN) begin
            state_d = NORMAL;
          end
        end
        HANDLER: begin
          if (eret) begin
            eret_take_d = 1'b1;
            state_d     = RETURN;
          end else if (not_an_instr) begin
            dbl_fault_d = 1'b1;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
    in_handler_d = (state_d == HANDLER);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NORMAL;
      irq_ack_q    <= '0;
      exc_take_q   <= 1'b0;
      eret_take_q  <= 1'b0;
      elr_q        <= '0;
      esr_q        <= '0;
      in_handler_q <= 1'b0;
      dbl_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_ack_q    <= irq_ack_d;
      exc_take_q   <= exc_take_d;
      eret_take_q  <= eret_take_d;
      elr_q        <= elr_d;
      esr_q        <= esr_d;
      in_handler_q <= in_handler_d;
      dbl_fault_q  <= dbl_fault_d;
    end
  end

  assign irq_ack    = irq_ack_q;
  assign exc_take   = exc_take_q;
  assign eret_take  = eret_take_q;
  assign flush      = exc_take_q | eret_take_q;
  assign elr_out    = elr_q;
  assign esr_out    = esr_q;
  assign in_handler = in_handler_q;
  assign dbl_fault  = dbl_fault_q;
  assign exc_vector = PC_W'(EXC_VECTOR);

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// tb_exc_ctrl_unit: directed-vector scoreboard bench for exc_ctrl_unit.
// Each stimulus cycle queues the hand-computed outputs expected after its edge;
// a monitor on the falling edge pops and compares them.
// Define EXC_IRQ_MASK_EN to also exercise the IRQ mask register.
module tb_exc_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        not_an_instr;
  logic        eret;
  logic [63:0] pc_dec;
  logic [3:0]  irq_req;
  logic [3:0]  irq_ack;
  logic        exc_take;
  logic [63:0] exc_vector;
  logic        eret_take;
  logic        flush;
  logic [63:0] elr_out;
  logic [3:0]  esr_out;
  logic        in_handler;
  logic        dbl_fault;
`ifdef EXC_IRQ_MASK_EN
  logic        irq_mask_we = 1'b0;
  logic [3:0]  irq_mask_wdata = 4'b0000;
`endif

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;

  typedef struct {
    longint      due;
    logic        exc;
    logic        ert;
    logic [3:0]  ack;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        inh;
    logic        dbl;
  } exp_t;

  exp_t sb[$];

  exc_ctrl_unit #(
    .N_IRQ(4), .PC_W(64), .ESR_W(4), .EXC_VECTOR(64'h0000_0000_0000_00D8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .not_an_instr(not_an_instr),
    .eret(eret),
    .pc_dec(pc_dec),
    .irq_req(irq_req),
`ifdef EXC_IRQ_MASK_EN
    .irq_mask_we(irq_mask_we),
    .irq_mask_wdata(irq_mask_wdata),
`endif
    .irq_ack(irq_ack),
    .exc_take(exc_take),
    .exc_vector(exc_vector),
    .eret_take(eret_take),
    .flush(flush),
    .elr_out(elr_out),
    .esr_out(esr_out),
    .in_handler(in_handler),
    .dbl_fault(dbl_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("exc_take",   64'(exc_take),   64'(e.exc));
    checkField("eret_take",  64'(eret_take),  64'(e.ert));
    checkField("flush",      64'(flush),      64'(e.exc | e.ert));
    checkField("irq_ack",    64'(irq_ack),    64'(e.ack));
    checkField("elr_out",    elr_out,         e.elr);
    checkField("esr_out",    64'(esr_out),    64'(e.esr));
    checkField("in_handler", 64'(in_handler), 64'(e.inh));
    checkField("dbl_fault",  64'(dbl_fault),  64'(e.dbl));
    checkField("exc_vector", exc_vector,      64'h0000_0000_0000_00D8);
  endtask

  // Monitor: every registered output set is compared against the queued expectation
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL late_check: actual cycle=%0d expected cycle=%0d", cyc, e.due);
      end
      checkOutput(e);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the sampling edge
  task automatic applyStimulus(
    input logic rst, input logic iv, input logic nai, input logic er,
    input logic [63:0] pc, input logic [3:0] irq,
    input logic xe, input logic xr, input logic [3:0] xa,
    input logic [63:0] xelr, input logic [3:0] xesr, input logic xi, input logic xd);
    exp_t e;
    reset        = rst;
    instr_valid  = iv;
    not_an_instr = nai;
    eret         = er;
    pc_dec       = pc;
    irq_req      = irq;
    e.due = cyc + 1;
    e.exc = xe;  e.ert = xr;  e.ack = xa;
    e.elr = xelr; e.esr = xesr; e.inh = xi; e.dbl = xd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; not_an_instr = 1'b0; eret = 1'b0;
    pc_dec = '0; irq_req = '0;
    @(posedge clk);
    #1;
    //            rst iv nai er pc      irq      exc ert ack      elr     esr inh dbl
    applyStimulus(1, 0, 0, 0, 64'h00, 4'b0000,  0, 0, 4'b0000, 64'h00, 4'd0, 0, 0);
    applyStimulus(0, 1, 1, 0, 64'h40, 4'b0000,  1, 0, 4'b0000, 64'h40, 4'd1, 1, 0);
    applyStimulus(0, 1, 0, 1, 64'h44, 4'b0000,  0, 1, 4'b0000, 64'h40, 4'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 64'h40, 4'b0001,  0, 0, 4'b0000, 64'h40, 4'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 64'h44, 4'b0001,  1, 0, 4'b0001, 64'h44, 4'd2, 1, 0);
    applyStimulus(0, 1, 0, 1, 64'hD8, 4'b0000,  0, 1, 4'b0000, 64'h44, 4'd2, 0, 0);
    applyStimulus(0, 0, 0, 0, 64'h44, 4'b0000,  0, 0, 4'b0000, 64'h44, 4'd2, 0, 0);
    applyStimulus(0, 1, 0, 0, 64'h44, 4'b0000,  0, 0, 4'b0000, 64'h44, 4'd2, 0, 0);
    applyStimulus(0, 1, 1, 0, 64'h80, 4'b1010,  1, 0, 4'b0000, 64'h80, 4'd1, 1, 0);
    applyStimulus(0, 1, 0, 1, 64'hDC, 4'b1010,  0, 1, 4'b0000, 64'h80, 4'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 64'h80, 4'b1010,  0, 0, 4'b0000, 64'h80, 4'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 64'h84, 4'b1010,  1, 0, 4'b0010, 64'h84, 4'd3, 1, 0);
    applyStimulus(0, 1, 1, 0, 64'hD8, 4'b1000,  0, 0, 4'b0000, 64'h84, 4'd3, 1, 1);
    applyStimulus(0, 1, 0, 1, 64'hDC, 4'b1000,  0, 1, 4'b0000, 64'h84, 4'd3, 0, 1);
    applyStimulus(0, 1, 0, 0, 64'h84, 4'b1000,  0, 0, 4'b0000, 64'h84, 4'd3, 0, 1);
    applyStimulus(0, 1, 0, 0, 64'h88, 4'b1000,  1, 0, 4'b1000, 64'h88, 4'd5, 1, 1);
    applyStimulus(0, 1, 0, 1, 64'hD8, 4'b0000,  0, 1, 4'b0000, 64'h88, 4'd5, 0, 1);
    applyStimulus(0, 1, 1, 0, 64'h90, 4'b0000,  1, 0, 4'b0000, 64'h90, 4'd1, 1, 1);
    applyStimulus(0, 1, 0, 1, 64'hD8, 4'b0000,  0, 1, 4'b0000, 64'h90, 4'd1, 0, 1);
    applyStimulus(0, 1, 0, 0, 64'h94, 4'b0000,  0, 0, 4'b0000, 64'h90, 4'd1, 0, 1);
    applyStimulus(0, 1, 0, 1, 64'h10, 4'b0000,  1, 0, 4'b0000, 64'h10, 4'd1, 1, 1);
    applyStimulus(1, 1, 0, 1, 64'hD8, 4'b0000,  0, 0, 4'b0000, 64'h00, 4'd0, 0, 0);
    applyStimulus(0, 1, 1, 0, 64'h20, 4'b0000,  1, 0, 4'b0000, 64'h20, 4'd1, 1, 0);
    applyStimulus(0, 1, 1, 0, 64'h24, 4'b0000,  0, 0, 4'b0000, 64'h20, 4'd1, 1, 1);
    applyStimulus(1, 0, 0, 0, 64'h00, 4'b0000,  0, 0, 4'b0000, 64'h00, 4'd0, 0, 0);
`ifdef EXC_IRQ_MASK_EN
    irq_mask_we = 1'b1; irq_mask_wdata = 4'b1110;
    applyStimulus(0, 0, 0, 0, 64'h00, 4'b0000,  0, 0, 4'b0000, 64'h00, 4'd0, 0, 0);
    irq_mask_we = 1'b0;
    applyStimulus(0, 1, 0, 0, 64'h30, 4'b0101,  1, 0, 4'b0100, 64'h30, 4'd4, 1, 0);
`endif
    applyStimulus(0, 0, 0, 0, 64'h00, 4'b0000,  0, 0, 4'b0000,
`ifdef EXC_IRQ_MASK_EN
                  64'h30, 4'd4, 1, 0);
`else
                  64'h00, 4'd0, 0, 0);
`endif
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: actual pending=%0d expected pending=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
